// File: rtl/sal_ddr2_pkg.sv
// sal_ddr2_pkg: types and helpers shared by the DDR2 request router.
//   map_mode_t  : run-time address mapping selector (value 3 decodes as RBC)
//   chan_t      : AXI address channel identifier (AR / AW)
//   bk_req_t    : request fields forwarded to a bank controller
//   dec_addr_t  : decoded bank plus request fields
//   decode_addr : splits a byte address into bank/row/column for a given mode
package sal_ddr2_pkg;

    // Fields are carried at full width so one package serves any
    // parameterisation; users slice down to their own widths.
    localparam int unsigned SAL_FIELD_W = 64;

    typedef enum logic [1:0] {
        MAP_RBC     = 2'd0,
        MAP_BRC     = 2'd1,
        MAP_RBC_XOR = 2'd2
    } map_mode_t;

    typedef enum logic {
        CH_AR = 1'b0,
        CH_AW = 1'b1
    } chan_t;

    typedef struct packed {
        logic [SAL_FIELD_W-1:0] id;
        logic [SAL_FIELD_W-1:0] ra;
        logic [SAL_FIELD_W-1:0] ca;
        logic [SAL_FIELD_W-1:0] len;
        logic                   wr;
    } bk_req_t;

    typedef struct packed {
        logic [SAL_FIELD_W-1:0] ba;
        bk_req_t                req;
    } dec_addr_t;

    function automatic logic [63:0] field_mask(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Only ra/ca/ba are filled; id/len/wr are left zero for the caller.
    function automatic dec_addr_t decode_addr(
        input logic [63:0] addr,
        input map_mode_t   mode,
        input int unsigned off_w,
        input int unsigned ca_w,
        input int unsigned ra_w,
        input int unsigned ba_w
    );
        logic [63:0] a;
        logic [63:0] ca;
        logic [63:0] ra;
        logic [63:0] ba;
        dec_addr_t   res;
        a  = addr >> off_w;
        ca = a & field_mask(ca_w);
        if (mode == MAP_BRC) begin
            ra = (a >> ca_w) & field_mask(ra_w);
            ba = (a >> (ca_w + ra_w)) & field_mask(ba_w);
        end else begin
            // RBC, RBC+XOR and the unused encoding 3
            ba = (a >> ca_w) & field_mask(ba_w);
            ra = (a >> (ca_w + ba_w)) & field_mask(ra_w);
            if (mode == MAP_RBC_XOR) begin
                ba = ba ^ (ra & field_mask(ba_w));
            end
        end
        res        = '0;
        res.ba     = ba;
        res.req.ra = ra;
        res.req.ca = ca;
        return res;
    endfunction

endpackage

// File: rtl/sal_rr_arb2.sv
// sal_rr_arb2: two-requester round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i[0]   : AR request, req_i[1] : AW request
//   accept_i   : the granted request was transferred this cycle
//   grant_o    : one-hot (or zero) grant, combinational from req_i
// Priority rotates only on an accepted transfer; after reset AR wins a tie.
module sal_rr_arb2
    import sal_ddr2_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    chan_t last_q;
    chan_t last_d;

    always_comb begin
        grant_o = '0;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_q == CH_AW) ? 2'b01 : 2'b10;
            default: grant_o = '0;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (accept_i) begin
            last_d = grant_o[1] ? CH_AW : CH_AR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= CH_AW;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sal_req_router.sv
// sal_req_router: arbitrates AXI AR/AW address requests, decodes the address
// into bank/row/column and presents it through a one-deep registered slot to
// the addressed bank controller.
//   clk, rst_n            : clock, asynchronous active-low reset
//   map_mode_i            : 0 RBC, 1 BRC, 2 RBC with XOR bank hash, 3 as 0
//   ar_* / aw_*           : AXI read / write address channels
//   bk_valid_o/bk_ready_i : one-hot per-bank handshake
//   bk_id/ra/ca/len/wr_o  : request fields shared by all banks (wr: 1 = write)
module sal_req_router
    import sal_ddr2_pkg::*;
#(
    parameter  int ADDR_WIDTH   = 32,
    parameter  int ID_WIDTH     = 4,
    parameter  int LEN_WIDTH    = 4,
    parameter  int BK_CNT       = 8,
    parameter  int RA_WIDTH     = 14,
    parameter  int CA_WIDTH     = 10,
    parameter  int OFFSET_WIDTH = 3,
    localparam int BA_WIDTH     = $clog2(BK_CNT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            map_mode_i,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    input  logic [ID_WIDTH-1:0]   ar_id_i,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [LEN_WIDTH-1:0]  ar_len_i,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [ID_WIDTH-1:0]   aw_id_i,
    input  logic [ADDR_WIDTH-1:0] aw_addr_i,
    input  logic [LEN_WIDTH-1:0]  aw_len_i,
    output logic [BK_CNT-1:0]     bk_valid_o,
    input  logic [BK_CNT-1:0]     bk_ready_i,
    output logic [ID_WIDTH-1:0]   bk_id_o,
    output logic [RA_WIDTH-1:0]   bk_ra_o,
    output logic [CA_WIDTH-1:0]   bk_ca_o,
    output logic [LEN_WIDTH-1:0]  bk_len_o,
    output logic                  bk_wr_o
);

    if ((BK_CNT < 2) || ((BK_CNT & (BK_CNT - 1)) != 0)) begin : g_bk_cnt_chk
        $error("sal_req_router: BK_CNT must be a power of two >= 2");
    end
    if ((ADDR_WIDTH < OFFSET_WIDTH + CA_WIDTH + RA_WIDTH + BA_WIDTH) ||
        (ADDR_WIDTH > 64)) begin : g_addr_chk
        $error("sal_req_router: ADDR_WIDTH too small for the mapping (or > 64)");
    end

    logic                  out_valid_q, out_valid_d;
    logic [BA_WIDTH-1:0]   out_ba_q,    out_ba_d;
    logic [ID_WIDTH-1:0]   id_q,        id_d;
    logic [RA_WIDTH-1:0]   ra_q,        ra_d;
    logic [CA_WIDTH-1:0]   ca_q,        ca_d;
    logic [LEN_WIDTH-1:0]  len_q,       len_d;
    logic                  wr_q,        wr_d;

    logic [1:0]            grant;
    logic                  slot_free;
    logic                  accept;
    logic                  drain;
    logic [ADDR_WIDTH-1:0] sel_addr;
    dec_addr_t             dec;
    logic                  unused_dec;

    assign slot_free  = !out_valid_q || bk_ready_i[out_ba_q];
    assign ar_ready_o = grant[0] && slot_free;
    assign aw_ready_o = grant[1] && slot_free;
    // Grants are only issued to valid requesters, so a grant plus a free
    // slot is exactly a transfer on the granted channel.
    assign accept     = (ar_valid_i && ar_ready_o) || (aw_valid_i && aw_ready_o);
    assign drain      = out_valid_q && bk_ready_i[out_ba_q];

    sal_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({aw_valid_i, ar_valid_i}),
        .accept_i (accept),
        .grant_o  (grant)
    );

    assign sel_addr   = grant[1] ? aw_addr_i : ar_addr_i;
    assign dec        = decode_addr(64'(sel_addr), map_mode_t'(map_mode_i),
                                    OFFSET_WIDTH, CA_WIDTH, RA_WIDTH, BA_WIDTH);
    assign unused_dec = ^dec;

    always_comb begin
        out_valid_d = out_valid_q;
        out_ba_d    = out_ba_q;
        id_d        = id_q;
        ra_d        = ra_q;
        ca_d        = ca_q;
        len_d       = len_q;
        wr_d        = wr_q;
        if (accept) begin
            // Covers a simultaneous drain: the slot reloads without a bubble.
            out_valid_d = 1'b1;
            out_ba_d    = dec.ba[BA_WIDTH-1:0];
            ra_d        = dec.req.ra[RA_WIDTH-1:0];
            ca_d        = dec.req.ca[CA_WIDTH-1:0];
            id_d        = grant[1] ? aw_id_i  : ar_id_i;
            len_d       = grant[1] ? aw_len_i : ar_len_i;
            wr_d        = grant[1];
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_ba_q    <= '0;
            id_q        <= '0;
            ra_q        <= '0;
            ca_q        <= '0;
            len_q       <= '0;
            wr_q        <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ba_q    <= out_ba_d;
            id_q        <= id_d;
            ra_q        <= ra_d;
            ca_q        <= ca_d;
            len_q       <= len_d;
            wr_q        <= wr_d;
        end
    end

    assign bk_valid_o = out_valid_q ? (BK_CNT'(1) << out_ba_q) : '0;
    assign bk_id_o    = id_q;
    assign bk_ra_o    = ra_q;
    assign bk_ca_o    = ca_q;
    assign bk_len_o   = len_q;
    assign bk_wr_o    = wr_q;

endmodule
